// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler.
//   data_t        : ALU operand / result word
//   op_type_e     : UNSIGNED or SIGNED interpretation of the operands
//   opcode_e      : ADD, SUB, MULT, DIV, SL (<<2), SR (>>2, arithmetic if SIGNED)
//   instruction_t : one requester's instruction (op_type, opc, op_a, op_b)
//   resp_t        : result bundle (data, id, err)
//   NUM_REQ_MAX   : largest supported requester count
package alu_scheduler_pkg;

   localparam int DATA_W      = 32;
   localparam int NUM_REQ_MAX = 8;
   localparam int ID_MAX_W    = $clog2(NUM_REQ_MAX);

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic {
      UNSIGNED = 1'b0,
      SIGNED   = 1'b1
   } op_type_e;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      MULT = 3'd2,
      DIV  = 3'd3,
      SL   = 3'd4,
      SR   = 3'd5
   } opcode_e;

   typedef struct packed {
      op_type_e op_type;
      opcode_e  opc;
      data_t    op_a;
      data_t    op_b;
   } instruction_t;

   typedef struct packed {
      data_t               data;
      logic [ID_MAX_W-1:0] id;
      logic                err;
   } resp_t;

   function automatic logic is_div_zero(input instruction_t instr);
      return (instr.opc == DIV) && (instr.op_b == '0);
   endfunction

endpackage

// File: rtl/alu_scheduler_alu.sv
// Combinational ALU shared by all requesters.
// Ports:
//   instr  : in  instruction_t, the granted instruction
//   result : out data_t, lower DATA_W bits of the operation result
module alu_scheduler_alu
   import alu_scheduler_pkg::*;
(
   input  instruction_t instr,
   output data_t        result
);

   logic is_signed;
   assign is_signed = (instr.op_type == SIGNED);

   always_comb begin
      result = '0;
      case (instr.opc)
         ADD:  result = instr.op_a + instr.op_b;
         SUB:  result = instr.op_a - instr.op_b;
         // Low half of the product is identical for signed and unsigned.
         MULT: result = instr.op_a * instr.op_b;
         DIV: begin
            // Divide by zero yields all ones rather than an undefined value.
            if (instr.op_b == '0)
               result = '1;
            else if (is_signed)
               result = data_t'($signed(instr.op_a) / $signed(instr.op_b));
            else
               result = instr.op_a / instr.op_b;
         end
         SL:   result = instr.op_a << 2;
         SR: begin
            if (is_signed)
               result = data_t'($signed(instr.op_a) >>> 2);
            else
               result = instr.op_a >> 2;
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_scheduler_rr_arbiter.sv
// Round-robin arbiter. Search begins one past the last granted index and
// wraps; the first set request bit wins.
// Ports:
//   req   : in  NUM_REQ request bits (already qualified by the caller)
//   ptr   : in  index of the last granted requester
//   grant : out one-hot grant, all zero when no request is set
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and
// a single result register (latency 1, one issue per cycle when drained).
// Optional feature macro: ALU_SCHED_DIVZERO_EN -- when defined, DIV by zero
// returns data 0 with resp_err set; otherwise resp_err is tied 0.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester valid
//   req_instr    : per-requester instruction
//   req_ready    : one-hot grant (transfer on valid & ready)
//   resp_valid   : result register holds a result
//   resp_ready   : consumer accepts the result
//   resp_data    : ALU result
//   resp_id      : index of the requester the result belongs to
//   resp_err     : divide-by-zero flag
//   issue_count  : instructions issued since reset (wraps)
//
// state | meaning
// EMPTY | result register empty
// FULL  | result register holds an unconsumed result
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int CNT_W   = 16,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic         [NUM_REQ-1:0] req_valid,
   input  instruction_t [NUM_REQ-1:0] req_instr,
   output logic         [NUM_REQ-1:0] req_ready,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output data_t                      resp_data,
   output logic         [IDX_W-1:0]   resp_id,
   output logic                       resp_err,
   output logic         [CNT_W-1:0]   issue_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               can_issue;
   logic               issue;
   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   gnt_idx;
   instruction_t       gnt_instr;
   data_t              alu_result;
   data_t              data_nxt;
   logic               err_nxt;

   assign resp_valid = (state == FULL);
   assign can_issue  = (state == EMPTY) | (resp_valid & resp_ready);

   // No grants while reset is held, even though the state already reads EMPTY.
   assign arb_req = req_valid & {NUM_REQ{can_issue & ~rst}};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req   (arb_req),
      .ptr   (last_grant),
      .grant (grant)
   );

   assign req_ready = grant;
   assign issue     = |grant;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i])
            gnt_idx = IDX_W'(i);
      end
   end

   assign gnt_instr = req_instr[gnt_idx];

   alu_scheduler_alu u_alu (
      .instr  (gnt_instr),
      .result (alu_result)
   );

`ifdef ALU_SCHED_DIVZERO_EN
   always_comb begin
      data_nxt = alu_result;
      err_nxt  = 1'b0;
      if (is_div_zero(gnt_instr)) begin
         data_nxt = '0;
         err_nxt  = 1'b1;
      end
   end
`else
   assign data_nxt = alu_result;
   assign err_nxt  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (issue) state_nxt = FULL;
         FULL:    if (resp_ready && !issue) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Result fields only load on issue, so they hold under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_data   <= '0;
         resp_id     <= '0;
         resp_err    <= 1'b0;
         issue_count <= '0;
         last_grant  <= IDX_W'(NUM_REQ - 1);
      end else if (issue) begin
         resp_data   <= data_nxt;
         resp_id     <= gnt_idx;
         resp_err    <= err_nxt;
         issue_count <= issue_count + CNT_W'(1);
         last_grant  <= gnt_idx;
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
module tb_alu_scheduler;
   import alu_scheduler_pkg::*;

   localparam int N  = 4;
   localparam int CW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic         [N-1:0] req_valid;
   instruction_t [N-1:0] req_instr;
   logic         [N-1:0] req_ready;
   logic                 resp_valid;
   logic                 resp_ready;
   data_t                resp_data;
   logic         [1:0]   resp_id;
   logic                 resp_err;
   logic        [CW-1:0] issue_count;

   always #5 clk = ~clk;

   alu_scheduler #(
      .NUM_REQ (N),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_instr   (req_instr),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_id     (resp_id),
      .resp_err    (resp_err),
      .issue_count (issue_count)
   );

   typedef struct {
      logic [31:0] data;
      int          id;
      logic        err;
      bit          care;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   m_last;
   int   m_cnt;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour written from the operation definitions.
   function automatic exp_t model_resp(input instruction_t in, input int id);
      exp_t        e;
      logic [31:0] a, b;
      bit          sgn, dz;
      a   = in.op_a;
      b   = in.op_b;
      sgn = (in.op_type == SIGNED);
      dz  = (in.opc == DIV) && (b == 0);
      e.id   = id;
      e.err  = 1'b0;
      e.care = 1'b1;
      e.data = '0;
      case (in.opc)
         ADD:  e.data = a + b;
         SUB:  e.data = a - b;
         MULT: e.data = a * b;
         DIV:  if (!dz) e.data = sgn ? 32'($signed(a) / $signed(b)) : a / b;
         SL:   e.data = a * 4;
         SR:   e.data = sgn ? 32'($signed(a) >>> 2) : a / 4;
         default: e.data = '0;
      endcase
`ifdef ALU_SCHED_DIVZERO_EN
      if (dz) begin
         e.data = '0;
         e.err  = 1'b1;
      end
`else
      if (dz) e.care = 1'b0;
`endif
      return e;
   endfunction

   function automatic instruction_t rand_instr();
      instruction_t in;
      in.op_type = op_type_e'($urandom_range(0, 1));
      in.opc     = opcode_e'($urandom_range(0, 5));
      in.op_a    = $urandom;
      in.op_b    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (in.opc == DIV && in.op_type == SIGNED && in.op_a == 32'h8000_0000 && in.op_b == 32'hffff_ffff)
         in.op_b = 32'd1;
      return in;
   endfunction

   function automatic instruction_t mk(input op_type_e t, input opcode_e o, input logic [31:0] a, input logic [31:0] b);
      instruction_t in;
      in.op_type = t;
      in.opc     = o;
      in.op_a    = a;
      in.op_b    = b;
      return in;
   endfunction

   // Checks interface state against the model at the negedge and records issues.
   task automatic drive_check();
      logic [N-1:0] eg;
      int           g;
      cmp("resp_valid", resp_valid, (sb.size() != 0));
      cmp("issue_count", issue_count, m_cnt);
      eg = '0;
      g  = -1;
      if (!rst && (sb.size() == 0 || resp_ready)) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_last + 1 + k) % N;
            if (g < 0 && req_valid[j]) g = j;
         end
      end
      if (g >= 0) eg[g] = 1'b1;
      cmp("req_ready", req_ready, eg);
      if (g >= 0) begin
         sb.push_back(model_resp(req_instr[g], g));
         m_last = g;
         m_cnt  = (m_cnt + 1) % (1 << CW);
      end
   endtask

   task automatic step();
      @(negedge clk);
      drive_check();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      sb.delete();
      m_last = N - 1;
      m_cnt  = 0;
      #1;
      cmp("rst_resp_valid", resp_valid, 1'b0);
      cmp("rst_issue_count", issue_count, 0);
      step();
      rst = 1'b0;
   endtask

   // Monitor: compares the presented result with the oldest expectation,
   // retires it on handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected actual=valid required=none (t=%0t)", $time);
            end else begin
               if (sb[0].care) cmp("resp_data", resp_data, sb[0].data);
               cmp("resp_id", resp_id, sb[0].id);
               cmp("resp_err", resp_err, sb[0].err);
               if (resp_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < N; i++) req_instr[i] = mk(UNSIGNED, ADD, 0, 0);
      m_last = N - 1;
      m_cnt  = 0;
      @(posedge clk);
      #1;
      apply_reset();
      cmp("reset_data", resp_data, 0);
      cmp("reset_id", resp_id, 0);
      cmp("reset_err", resp_err, 0);
      cmp("reset_ready", req_ready, 0);

      // Single request: SIGNED ADD 5 + -3.
      req_instr[0] = mk(SIGNED, ADD, 32'd5, 32'hffff_fffd);
      req_valid    = 4'b0001;
      resp_ready   = 1'b1;
      step();
      req_valid = '0;
      cmp("add_valid", resp_valid, 1'b1);
      cmp("add_data", resp_data, 32'd2);
      cmp("add_id", resp_id, 0);
      cmp("add_count", issue_count, 1);
      step();

      // Fairness: all requesters valid, consumer always ready.
      apply_reset();
      req_valid  = '1;
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         for (int r = 0; r < N; r++) req_instr[r] = rand_instr();
         #1;
         cmp("fair_grant", req_ready, 4'b0001 << (i % N));
         step();
      end

      // Backpressure: hold the result 3 cycles, then drain and issue together.
      req_valid  = '0;
      step();
      step();
      req_valid  = '1;
      resp_ready = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         cmp("bp_ready_low", req_ready, 0);
         step();
      end
      resp_ready = 1'b1;
      #1;
      cmp("bp_drain_grant", (req_ready != 0), 1'b1);
      step();
      req_valid = '0;
      step();

      // Divide by zero and shift-right boundary cases on requester 2.
      req_valid      = 4'b0100;
      req_instr[2]   = mk(UNSIGNED, DIV, 32'd7, 32'd0);
      step();
`ifdef ALU_SCHED_DIVZERO_EN
      cmp("divz_data", resp_data, 0);
      cmp("divz_err", resp_err, 1'b1);
`else
      cmp("divz_err", resp_err, 1'b0);
`endif
      req_instr[2] = mk(UNSIGNED, SR, 32'd16, 32'd0);
      step();
      cmp("sr_unsigned", resp_data, 32'd4);
      req_instr[2] = mk(SIGNED, SR, 32'hffff_fff0, 32'd0);
      step();
      cmp("sr_signed", resp_data, 32'hffff_fffc);
      req_valid = '0;
      step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         req_valid  = N'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < N; r++) req_instr[r] = rand_instr();
         step();
      end

      // Reset while a result is held.
      req_valid  = 4'b0010;
      resp_ready = 1'b0;
      step();
      step();
      cmp("pre_rst_full", resp_valid, 1'b1);
      apply_reset();
      req_valid  = '1;
      resp_ready = 1'b1;
      #1;
      cmp("post_rst_grant", req_ready, 4'b0001);
      step();

      // Counter wrap with a 4-bit counter.
      apply_reset();
      req_valid = '1;
      for (int i = 0; i < 16; i++) begin
         for (int r = 0; r < N; r++) req_instr[r] = rand_instr();
         step();
         if (i == 14) cmp("count_15", issue_count, 15);
      end
      cmp("count_wrap", issue_count, 0);

      req_valid  = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      cmp("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one ALU (2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of issue counter.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port req_instr  input  NUM_REQ x instruction_t  per-requester instruction (op_type, opc, op_a, op_b).
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
REQ-008 SHALL have port resp_valid  output  1  result register holds a result.
REQ-009 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port resp_data  output  data_t  ALU result.
REQ-011 SHALL have port resp_id  output  $clog2(NUM_REQ)  index of originating requester.
REQ-012 SHALL have port resp_err  output  1  divide-by-zero flag (see Configuration).
REQ-013 SHALL have port issue_count  output  CNT_W  number of instructions issued since reset.

Function
REQ-014 SHALL contain one ALU instance computing data_t from the granted instruction, SIGNED/UNSIGNED per op_type; opcodes ADD, SUB, MULT, DIV, SL (shift left 2), SR (shift right 2, arithmetic if SIGNED).
REQ-015 SHALL use FSM states EMPTY (result reg empty) and FULL (result reg holds unconsumed result).
REQ-016 SHALL define can_issue = (state==EMPTY) | (resp_valid & resp_ready).
REQ-017 SHALL assert at most one req_ready bit, only when can_issue and that req_valid bit is set; req_ready is combinational from req_valid, pointer and state.
REQ-018 SHALL arbitrate round-robin: search starts at index (last_grant+1) mod NUM_REQ; pointer updates only on an issue.
REQ-019 SHALL register result, id and err on issue; resp_valid rises the cycle after the grant (latency 1).
REQ-020 SHALL sustain one issue per cycle while resp_ready stays high (drain and issue same cycle: state stays FULL).
REQ-021 SHALL hold resp_data/resp_id/resp_err stable while resp_valid & !resp_ready.
REQ-022 SHALL transition FULL->EMPTY on drain with no simultaneous issue; EMPTY->FULL on issue.
REQ-023 SHALL increment issue_count on each issue, wrapping from 2^CNT_W-1 to 0.
REQ-024 SHALL ignore req_instr of non-granted requesters; a requester deasserting req_valid before grant is legal.

Reset
REQ-025 SHALL on rst: state=EMPTY, resp_valid=0, resp_data=0, resp_id=0, resp_err=0, issue_count=0, last_grant=NUM_REQ-1 (requester 0 first), req_ready=0.
REQ-026 SHALL discard any held result when rst asserts mid-operation; no response is produced for it.

Configuration
REQ-027 SHALL honour macro ALU_SCHED_DIVZERO_EN.
REQ-028 With ALU_SCHED_DIVZERO_EN defined: DIV with op_b==0 is issued normally, resp_data=0, resp_err=1; ALU divide result unused.
REQ-029 Without it: DIV by zero passes the ALU value through unchecked (value don't-care), resp_err tied 0.

Structure
REQ-030 SHALL take instruction_t, data_t, opcode and op_type enums from the shared definitions package; SHALL add there resp_t (data, id, err) and constant NUM_REQ_MAX=8.
REQ-031 SHALL place the round-robin grant logic in sub-module rr_arbiter (req, pointer in; one-hot grant out).

Verification
REQ-032 Single request: req 0 ADD SIGNED 5,-3 -> req_ready[0] same cycle, next cycle resp_valid=1, resp_data=2, resp_id=0, issue_count=1.
REQ-033 Fairness: all 4 valid continuously, resp_ready=1 -> grant order 0,1,2,3,0,...; one response per cycle.
REQ-034 Backpressure: resp_ready=0 for 3 cycles after first result -> req_ready all 0, resp outputs stable; resp_ready=1 -> drain and next grant same cycle.
REQ-035 Div-zero: UNSIGNED DIV 7,0 with ALU_SCHED_DIVZERO_EN -> resp_data=0, resp_err=1; UNSIGNED SR 16 -> 4, SIGNED SR -16 -> -4.
REQ-036 Reset mid-op: rst while FULL -> resp_valid=0 immediately, issue_count=0, next grant goes to requester 0; counter wrap with CNT_W=4 after 16 issues reads 0.
